// File: rtl/ahb_sram_bridge.sv
// ahb_sram_bridge: AHB-Lite slave front end for a single-port synchronous SRAM
// (1-cycle registered read). Zero wait states for reads and writes.
// A one-entry write buffer holds write data whose data phase collides with a
// read address phase; buffered lanes are forwarded to later reads of the word.
// Optional feature macro: AHB_SRAM_RANGE_CHECK_EN -- accesses at or above
// MEM_WORDS are not issued and receive a two-cycle ERROR response.
module ahb_sram_bridge #(
  parameter int AW        = 18,
  parameter int MEM_WORDS = 65536
) (
  input  logic          HCLK,
  input  logic          HRESET,
  input  logic          HSEL,
  input  logic          HREADY,
  input  logic [1:0]    HTRANS,
  input  logic [2:0]    HSIZE,
  input  logic          HWRITE,
  input  logic [AW-1:0] HADDR,
  input  logic [31:0]   HWDATA,
  output logic          HREADYOUT,
  output logic          HRESP,
  output logic [31:0]   HRDATA,
  output logic [AW-3:0] SRAMADDR,
  output logic [31:0]   SRAMWDATA,
  output logic [3:0]    SRAMWEN,
  output logic          SRAMCS,
  input  logic [31:0]   SRAMRDATA
);

  // Byte-lane enables of a transfer from its size and low address bits.
  function automatic logic [3:0] lane_mask(input logic [2:0] size, input logic [1:0] lo);
    logic [3:0] m;
    case (size)
      3'd0:    m = 4'b0001 << lo;
      3'd1:    m = 4'b0011 << {lo[1], 1'b0};
      default: m = 4'b1111;
    endcase
    return m;
  endfunction

  // Overlay the enabled lanes of the buffered word onto SRAM read data.
  function automatic logic [31:0] lane_merge(input logic [31:0] base, input logic [31:0] ovl,
                                             input logic [3:0] en);
    logic [31:0] r;
    r = base;
    for (int b = 0; b < 4; b++) begin
      if (en[b]) r[8*b +: 8] = ovl[8*b +: 8];
    end
    return r;
  endfunction

  logic [AW-3:0] haddr_word;
  logic [3:0]    hmask;
  logic          acc;
  logic          addr_oor;
  logic          acc_ok;
  logic          rd_acc;
  logic          wr_acc;

  // Address-phase registers (data phase context)
  logic          wr_dp_q, wr_dp_d;
  logic          rd_dp_q, rd_dp_d;
  logic [AW-3:0] ap_addr_q;
  logic [3:0]    ap_mask_q;
  logic [AW-3:0] rd_addr_q;

  // One-entry write buffer
  logic          buf_valid_q, buf_valid_d;
  logic [AW-3:0] buf_addr_q;
  logic [3:0]    buf_mask_q;
  logic [31:0]   buf_data_q;

  logic          wr_issued;
  logic          buf_commit;
  logic          buf_load;
  logic          fwd_hit;
  logic          rd_data_en;

  logic          unused_ok;

  assign haddr_word = HADDR[AW-1:2];
  assign hmask      = lane_mask(HSIZE, HADDR[1:0]);
  assign acc        = HSEL & HREADY & HTRANS[1];

`ifdef AHB_SRAM_RANGE_CHECK_EN
  localparam logic [1:0] ST_OK   = 2'd0;
  localparam logic [1:0] ST_ERR1 = 2'd1;
  localparam logic [1:0] ST_ERR2 = 2'd2;

  logic [1:0] state_q, state_d;
  logic       acc_err;

  assign addr_oor = (32'(haddr_word) >= MEM_WORDS);
  assign acc_err  = acc & addr_oor;

  // Two-cycle ERROR response sequencing for out-of-range transfers.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_OK:   if (acc_err) state_d = ST_ERR1;
      ST_ERR1: state_d = ST_ERR2;
      ST_ERR2: state_d = acc_err ? ST_ERR1 : ST_OK;
      default: state_d = ST_OK;
    endcase
  end

  // Error state register.
  always_ff @(posedge HCLK) begin
    if (HRESET) state_q <= ST_OK;
    else        state_q <= state_d;
  end

  assign HREADYOUT  = (state_q != ST_ERR1);
  assign HRESP      = (state_q == ST_ERR1) || (state_q == ST_ERR2);
  assign rd_data_en = rd_dp_q & (state_q == ST_OK);
`else
  assign addr_oor   = 1'b0;
  assign HREADYOUT  = 1'b1;
  assign HRESP      = 1'b0;
  assign rd_data_en = rd_dp_q;
`endif

  assign acc_ok = acc & ~addr_oor;
  assign rd_acc = acc_ok & ~HWRITE;
  assign wr_acc = acc_ok &  HWRITE;

  // SRAM port arbitration: read address phase, then buffer commit, then direct write.
  always_comb begin
    SRAMCS     = 1'b0;
    SRAMWEN    = 4'b0000;
    SRAMADDR   = haddr_word;
    SRAMWDATA  = 32'h0;
    wr_issued  = 1'b0;
    buf_commit = 1'b0;
    if (rd_acc) begin
      SRAMCS   = 1'b1;
      SRAMADDR = haddr_word;
    end else if (buf_valid_q) begin
      SRAMCS     = 1'b1;
      SRAMADDR   = buf_addr_q;
      SRAMWDATA  = buf_data_q;
      SRAMWEN    = buf_mask_q;
      buf_commit = 1'b1;
    end else if (wr_dp_q) begin
      SRAMCS    = 1'b1;
      SRAMADDR  = ap_addr_q;
      SRAMWDATA = HWDATA;
      SRAMWEN   = ap_mask_q;
      wr_issued = 1'b1;
    end
  end

  // A write data phase that lost the SRAM port parks its data in the buffer.
  assign buf_load = wr_dp_q & ~wr_issued;

  // Next-state for control flags.
  always_comb begin
    wr_dp_d     = wr_acc;
    rd_dp_d     = rd_acc;
    buf_valid_d = buf_valid_q;
    if (buf_load)        buf_valid_d = 1'b1;
    else if (buf_commit) buf_valid_d = 1'b0;
  end

  // Control state: the only registers cleared by reset.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      wr_dp_q     <= 1'b0;
      rd_dp_q     <= 1'b0;
      buf_valid_q <= 1'b0;
    end else begin
      wr_dp_q     <= wr_dp_d;
      rd_dp_q     <= rd_dp_d;
      buf_valid_q <= buf_valid_d;
    end
  end

  // Address-phase capture and buffer payload; qualified by control flags.
  always_ff @(posedge HCLK) begin
    if (wr_acc) begin
      ap_addr_q <= haddr_word;
      ap_mask_q <= hmask;
    end
    if (rd_acc) begin
      rd_addr_q <= haddr_word;
    end
    if (buf_load) begin
      buf_addr_q <= ap_addr_q;
      buf_mask_q <= ap_mask_q;
      buf_data_q <= HWDATA;
    end
  end

  // Read data phase: SRAM data with any newer buffered lanes overlaid.
  assign fwd_hit = buf_valid_q && (buf_addr_q == rd_addr_q);

  always_comb begin
    HRDATA = 32'h0;
    if (rd_data_en) begin
      HRDATA = fwd_hit ? lane_merge(SRAMRDATA, buf_data_q, buf_mask_q) : SRAMRDATA;
    end
  end

  // HTRANS[0] (SEQ vs NONSEQ) does not change behaviour.
  assign unused_ok = ^{HTRANS[0], (MEM_WORDS > 0)};

endmodule

// File: tb/tb_ahb_sram_bridge.sv
// tb_ahb_sram_bridge: directed and random AHB traffic against ahb_sram_bridge
// with a behavioural SRAM and a byte-level reference memory.
`timescale 1ns/1ps
module tb_ahb_sram_bridge;
  localparam int AW = 18;
`ifdef AHB_SRAM_RANGE_CHECK_EN
  localparam int MEM_WORDS = 256;
`else
  localparam int MEM_WORDS = 65536;
`endif
  localparam int NW = 1 << (AW-2);

  logic          hclk = 1'b0;
  logic          hreset, hsel, hwrite, hready, hreadyout, hresp, sramcs;
  logic [1:0]    htrans;
  logic [2:0]    hsize;
  logic [AW-1:0] haddr;
  logic [31:0]   hwdata, hrdata, sramwdata, sramrdata;
  logic [AW-3:0] sramaddr;
  logic [3:0]    sramwen;

  int n_assert, n_fail;

  // Data-phase bookkeeping of the transfer accepted in the previous cycle
  bit          dp_v, dp_w;
  logic [2:0]  dp_sz;
  int          dp_a;
  logic [31:0] dp_wd;

  // Values sampled at the last negedge
  logic        s_cs;
  logic [3:0]  s_wen;
  logic [31:0] s_addr, s_wdata, s_hrdata;

  assign hready = hreadyout;
  always #5 hclk = ~hclk;

  ahb_sram_bridge #(.AW(AW), .MEM_WORDS(MEM_WORDS)) dut (
    .HCLK(hclk), .HRESET(hreset), .HSEL(hsel), .HREADY(hready), .HTRANS(htrans),
    .HSIZE(hsize), .HWRITE(hwrite), .HADDR(haddr), .HWDATA(hwdata),
    .HREADYOUT(hreadyout), .HRESP(hresp), .HRDATA(hrdata),
    .SRAMADDR(sramaddr), .SRAMWDATA(sramwdata), .SRAMWEN(sramwen),
    .SRAMCS(sramcs), .SRAMRDATA(sramrdata)
  );

  function automatic logic [31:0] preload(input int w);
    return (32'(w) * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // Behavioural SRAM: unwritten words read back their preload pattern
  bit [31:0] sram_mem [0:NW-1];
  bit        sram_wr  [0:NW-1];

  function automatic logic [31:0] sram_peek(input int w);
    return sram_wr[w] ? sram_mem[w] : preload(w);
  endfunction

  function automatic logic [31:0] en_merge(input logic [31:0] old, input logic [31:0] nw,
                                           input logic [3:0] en);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (en[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  always @(posedge hclk) begin
    if (sramcs) begin
      if (sramwen == 4'b0000) begin
        sramrdata <= sram_peek(int'(sramaddr));
      end else begin
        sram_mem[int'(sramaddr)] <= en_merge(sram_peek(int'(sramaddr)), sramwdata, sramwen);
        sram_wr[int'(sramaddr)]  <= 1'b1;
      end
    end
  end

  // Reference memory: the value every read must return under AHB ordering
  logic [31:0] ref_mem [int];

  function automatic logic [31:0] ref_rd(input int a);
    return ref_mem.exists(a / 4) ? ref_mem[a / 4] : preload(a / 4);
  endfunction

  task automatic ref_write(input int a, input logic [2:0] sz, input logic [31:0] wd);
    int nb, off;
    logic [31:0] cur;
    nb  = 1 << int'(sz);
    off = ((a % 4) / nb) * nb;
    cur = ref_rd(a);
    for (int b = 0; b < 4; b++) begin
      if (b >= off && b < off + nb) cur[8*b +: 8] = wd[8*b +: 8];
    end
    ref_mem[a / 4] = cur;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One bus cycle: new address phase plus data phase of the previous transfer
  task automatic step(input bit rst, input bit sel, input logic [1:0] tr, input bit w,
                      input logic [2:0] sz, input logic [AW-1:0] a, input logic [31:0] wd);
    hreset = rst;
    hsel   = sel;
    htrans = tr;
    hwrite = w;
    hsize  = sz;
    haddr  = a;
    hwdata = (dp_v && dp_w) ? dp_wd : $urandom();
    @(negedge hclk);
    s_cs     = sramcs;
    s_wen    = sramwen;
    s_addr   = 32'(sramaddr);
    s_wdata  = sramwdata;
    s_hrdata = hrdata;
    if (!rst) begin
      chk("hreadyout", 32'(hreadyout), 32'd1);
      chk("hresp", 32'(hresp), 32'd0);
      if (dp_v && !dp_w) chk("hrdata", hrdata, ref_rd(dp_a));
      else               chk("hrdata_idle", hrdata, 32'd0);
    end
    if (dp_v && dp_w) ref_write(dp_a, dp_sz, dp_wd);
    dp_v  = sel && tr[1] && !rst;
    dp_w  = w;
    dp_sz = sz;
    dp_a  = int'(a);
    dp_wd = wd;
    @(posedge hclk);
    #1;
  endtask

  task automatic wr(input int a, input logic [2:0] sz, input logic [31:0] wd);
    step(1'b0, 1'b1, 2'b10, 1'b1, sz, AW'(a), wd);
  endtask

  task automatic rd(input int a);
    step(1'b0, 1'b1, 2'b10, 1'b0, 3'd2, AW'(a), 32'h0);
  endtask

  task automatic idle();
    step(1'b0, 1'b1, 2'b00, 1'b0, 3'd0, '0, 32'h0);
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    dp_v = 0; dp_w = 0; dp_sz = 0; dp_a = 0; dp_wd = 0;
    hreset = 1'b1; hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0;
    hsize = 3'd0; haddr = '0; hwdata = 32'h0;
    @(posedge hclk);
    #1;

    // Power-on reset, then idle with reset released
    step(1'b1, 1'b0, 2'b00, 1'b0, 3'd0, '0, 32'h0);
    step(1'b1, 1'b0, 2'b00, 1'b0, 3'd0, '0, 32'h0);
    idle();

    // Reset asserted in the middle of a read burst
    rd(32'h0); rd(32'h4); rd(32'h8);
    step(1'b1, 1'b1, 2'b10, 1'b0, 3'd2, AW'(32'hC), 32'h0);
    idle();
    chk("rst_hrdata", s_hrdata, 32'h0);
    rd(32'h0); idle();
    chk("preload0", s_hrdata, preload(0));

    // Word write followed by idle: direct write in the data phase
    wr(32'h100, 3'd2, 32'hDEADBEEF); idle();
    chk("w100_cs", 32'(s_cs), 32'd1);
    chk("w100_wen", 32'(s_wen), 32'hF);
    chk("w100_addr", s_addr, 32'h40);
    chk("w100_wdata", s_wdata, 32'hDEADBEEF);
    rd(32'h100); idle();
    chk("r100", s_hrdata, 32'hDEADBEEF);

    // Byte write then back-to-back read of the same word: buffered and forwarded
    wr(32'h102, 3'd0, 32'h11AA2233); rd(32'h100);
    chk("rdwin_cs", 32'(s_cs), 32'd1);
    chk("rdwin_wen", 32'(s_wen), 32'h0);
    chk("rdwin_addr", s_addr, 32'h40);
    idle();
    chk("fwd_data", s_hrdata, 32'hDEAABEEF);
    chk("commit_wen", 32'(s_wen), 32'h4);
    chk("commit_addr", s_addr, 32'h40);
    chk("commit_byte", 32'(s_wdata[23:16]), 32'hAA);
    rd(32'h100); idle();
    chk("r100_after", s_hrdata, 32'hDEAABEEF);

    // Two writes then two reads with no gap
    wr(32'h200, 3'd2, 32'h01234567); wr(32'h204, 3'd2, 32'h89ABCDEF);
    rd(32'h300); rd(32'h304); idle();
    rd(32'h200); rd(32'h204); idle();

    // Half-word and byte lane enables
    wr(32'h202, 3'd1, 32'hCAFE5555); idle();
    chk("half_wen", 32'(s_wen), 32'hC);
    wr(32'h003, 3'd0, 32'h77000000); idle();
    chk("byte_wen", 32'(s_wen), 32'h8);
    rd(32'h200); rd(32'h0); idle();

    // Random traffic over a small window so buffer hits are frequent
    for (int i = 0; i < 400; i++) begin
      int k, word, off;
      logic [2:0] sz;
      bit w;
      k    = int'($urandom_range(0, 9));
      word = 32'h80 + int'($urandom_range(0, 15));
      sz   = 3'($urandom_range(0, 2));
      w    = 1'($urandom_range(0, 1));
      if (sz == 3'd0)      off = int'($urandom_range(0, 3));
      else if (sz == 3'd1) off = 2 * int'($urandom_range(0, 1));
      else                 off = 0;
      case (k)
        0:       idle();
        1:       step(1'b0, 1'b1, 2'b01, w, sz, AW'(word*4 + off), $urandom());
        2:       step(1'b0, 1'b0, 2'b10, w, sz, AW'(word*4 + off), $urandom());
        3:       step(1'b0, 1'b1, 2'b11, w, sz, AW'(word*4 + off), $urandom());
        default: step(1'b0, 1'b1, 2'b10, w, sz, AW'(word*4 + off), $urandom());
      endcase
    end
    idle(); idle();

    // SRAM contents must match the reference once the buffer has drained
    for (int wd = 32'h80; wd < 32'h90; wd++) chk("sram_word", sram_peek(wd), ref_rd(wd*4));
    chk("sram_w40", sram_peek(32'h40), ref_rd(32'h100));
    chk("sram_w0", sram_peek(0), ref_rd(0));

`ifdef AHB_SRAM_RANGE_CHECK_EN
    // Out-of-range read: not issued, two-cycle ERROR response
    hreset = 1'b0; hsel = 1'b1; htrans = 2'b10; hwrite = 1'b0; hsize = 3'd2;
    haddr = AW'(MEM_WORDS * 4);
    @(negedge hclk);
    chk("oor_cs", 32'(sramcs), 32'd0);
    @(posedge hclk); #1;
    htrans = 2'b00;
    @(negedge hclk);
    chk("err1_ready", 32'(hreadyout), 32'd0);
    chk("err1_resp", 32'(hresp), 32'd1);
    chk("err1_rdata", hrdata, 32'd0);
    chk("err1_cs", 32'(sramcs), 32'd0);
    @(posedge hclk); #1;
    @(negedge hclk);
    chk("err2_ready", 32'(hreadyout), 32'd1);
    chk("err2_resp", 32'(hresp), 32'd1);
    chk("err2_rdata", hrdata, 32'd0);
    @(posedge hclk); #1;
    dp_v = 0;
    idle();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
